// File: rtl/nbit_demux_buffered_if.sv
// Handshake bundle for the buffered 1-to-4 demultiplexer.
// master: producer plus the four consumers (drives words in, takes words out).
// slave:  the demultiplexer itself.
interface nbit_demux_buffered_if #(
  parameter int N = 4
);
  logic [N-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     sel;
  logic [4*N-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/nbit_demux_buffered.sv
// Buffered 1-to-4 demultiplexer: each accepted word is written to the tail of
// one of four per-channel FIFOs, each drained by its own valid/ready consumer.
// Optional feature macro DEMUX_RR_EN: when defined, sel is ignored and words
// are distributed round-robin (0,1,2,3,0,...) by an internal pointer that only
// advances on accepted words and never skips a full channel.
module nbit_demux_buffered #(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  nbit_demux_buffered_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [N-1:0]   mem_q    [4][DEPTH];
  logic [N-1:0]   mem_d    [4][DEPTH];
  logic [PW-1:0]  rd_ptr_q [4];
  logic [PW-1:0]  rd_ptr_d [4];
  logic [PW-1:0]  wr_ptr_q [4];
  logic [PW-1:0]  wr_ptr_d [4];
  logic [CW-1:0]  cnt_q    [4];
  logic [CW-1:0]  cnt_d    [4];

  logic [1:0]     dest;
  logic [3:0]     full;
  logic [3:0]     not_empty;
  logic [3:0]     push_ch;
  logic [3:0]     pop_ch;
  logic           push;
  logic [4*N-1:0] out_data_c;

`ifdef DEMUX_RR_EN
  logic [1:0] rr_ptr_q;
  logic [1:0] rr_ptr_d;
  logic [1:0] unused_sel;

  assign unused_sel = bus.sel;
  assign dest       = rr_ptr_q;

  // Round-robin pointer advances only when a word is actually accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      rr_ptr_d = rr_ptr_q + 2'd1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 2'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign dest = bus.sel;
`endif

  // Ready depends only on the destination FIFO's registered state, so a
  // same-cycle pop on a full channel cannot open the input (no bypass).
  assign bus.in_ready  = ~full[dest];
  assign push          = bus.in_valid & bus.in_ready;
  assign bus.out_valid = not_empty;
  assign bus.out_data  = out_data_c;

  // Per-channel status, handshake qualifiers and head-word presentation.
  always_comb begin
    full       = '0;
    not_empty  = '0;
    push_ch    = '0;
    pop_ch     = '0;
    out_data_c = '0;
    for (int k = 0; k < 4; k++) begin
      full[k]               = (cnt_q[k] == FULL_CNT);
      not_empty[k]          = (cnt_q[k] != '0);
      pop_ch[k]             = not_empty[k] & bus.out_ready[k];
      push_ch[k]            = push & (dest == 2'(k));
      out_data_c[k*N +: N]  = mem_q[k][rd_ptr_q[k]];
    end
  end

  // FIFO next state: write at tail, advance head, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (push_ch[k]) begin
        mem_d[k][wr_ptr_q[k]] = bus.in_data;
        wr_ptr_d[k]           = wr_ptr_q[k] + PW'(1);
      end
      if (pop_ch[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
      end
      case ({push_ch[k], pop_ch[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  // FIFO state registers; reset discards all in-flight words and clears storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        rd_ptr_q[k] <= '0;
        wr_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[k][d] <= '0;
        end
      end
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
